ring_decoder: RTL

RING_DECODER -- requirements
Module: ring_decoder

---
 rtl/ring_decoder.sv | 123 ++++++++++++
 1 files changed

// File: rtl/ring_decoder.sv
// ring_decoder
//   Tracks a one-hot ring counter and reports the binary index of its hot bit.
//   Locks onto the first legal pattern, checks every later sample against the
//   expected successor, counts completed revolutions and detected faults, and
//   resynchronises on the next legal pattern after a fault.
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   en       sample qualifier: ring advanced this cycle
//   clr      synchronous clear of state and counters (priority over en)
//   ring     one-hot state vector (N bits)
//   idx      binary index of the hot bit last accepted
//   valid    idx is trustworthy (LOCKED)
//   err      one-cycle pulse on a detected sequence fault
//   wrap     one-cycle pulse on an accepted N-1 -> 0 transition
//   rev_cnt  completed revolutions, wraps modulo 2^CNT_W
//   err_cnt  detected faults, saturates at all-ones
module ring_decoder #(
    parameter int N     = 4,
    parameter int CNT_W = 8,
    localparam int W    = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [N-1:0]     ring,
    output logic [W-1:0]     idx,
    output logic             valid,
    output logic             err,
    output logic             wrap,
    output logic [CNT_W-1:0] rev_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int PW = $clog2(N + 1);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED   = 2'd1,
        FAULT    = 2'd2
    } state_t;

    state_t        state;
    logic [PW-1:0] hot_cnt;
    logic [W-1:0]  hot_idx;
    logic          one_hot;
    logic          at_last;
    logic [W-1:0]  succ_idx;
    logic [N-1:0]  exp_ring;

    // Population count and position of the (last) set bit of ring.
    always_comb begin
        hot_cnt = '0;
        hot_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (ring[i]) begin
                hot_cnt = hot_cnt + PW'(1);
                hot_idx = W'(i);
            end
        end
    end

    assign one_hot  = (hot_cnt == PW'(1));
    assign at_last  = (idx == W'(N - 1));
    // Explicit wrap needed: N need not be a power of two.
    assign succ_idx = at_last ? '0 : idx + W'(1);
    assign exp_ring = N'(1) << succ_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= UNLOCKED;
            idx     <= '0;
            valid   <= 1'b0;
            err     <= 1'b0;
            wrap    <= 1'b0;
            rev_cnt <= '0;
            err_cnt <= '0;
        end else begin
            err  <= 1'b0;
            wrap <= 1'b0;
            if (clr) begin
                state   <= UNLOCKED;
                idx     <= '0;
                valid   <= 1'b0;
                rev_cnt <= '0;
                err_cnt <= '0;
            end else if (en) begin
                case (state)
                    UNLOCKED, FAULT: begin
                        // Illegal patterns are ignored silently until a legal one arrives.
                        if (one_hot) begin
                            idx   <= hot_idx;
                            state <= LOCKED;
                            valid <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (ring == exp_ring) begin
                            idx <= succ_idx;
                            if (at_last) begin
                                wrap    <= 1'b1;
                                rev_cnt <= rev_cnt + CNT_W'(1);
                            end
                        end else begin
                            err   <= 1'b1;
                            state <= FAULT;
                            valid <= 1'b0;
                            if (err_cnt != '1)
                                err_cnt <= err_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= UNLOCKED;
                        valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
